tank_input_ctrl: RTL
====================

# tank_input_ctrl

Upstream stage of the projectile engine. It synchronises and debounces the five raw push-buttons and turns them into the controls the engine consumes:
- a firing-angle select per player;
- a stretched fire level;
- per-player tank positions.

It holds off all control changes while a shot is in flight, and applies movement and aiming only to the player whose turn it is.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed to accept a new button level (20 ms at 50 MHz)
- MOVE_DIV, 500000: cycles between one-pixel moves while a direction is held
- FIRE_LEN, 4: cycles the fire output stays high per accepted press
- X0_INIT, 100 / X1_INIT, 520: reset x positions
- Y_GROUND, 380: constant y of both tanks
- X0_MIN, 0 / X0_MAX, 280: player 0 x clamp
- X1_MIN, 340 / X1_MAX, 620: player 1 x clamp (keeps tanks off the obstacle at x 300..340)

Ports (one clock, clk50; reset rst is synchronous and active-high):
- clk50  in  1  system clock
- rst  in  1  synchronous active-high reset
- btnL, btnR, btnU, btnD, btnM  in  1 each  raw asynchronous buttons
- turn  in  1  active player from the projectile engine (0 or 1)
- shooting  in  1  high while a shot is in flight
- M  out  1  fire level to the engine
- sel  out  4  active player's angle, 0..9
- player_x0, player_y0, player_x1, player_y1  out  10 each  tank positions

## Operation

- **Input sync:** each button passes through a 2-flop synchroniser.
- **Debounce (per button):**
  - The counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments.
  - When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A rising edge of a debounced level produces a one-cycle press pulse.
- **Angle registers:** ang0 and ang1, 4 bits each, reset to 0.
  - U press with shooting=0: ang[turn] increments, saturating at 9.
  - D press with shooting=0: ang[turn] decrements, saturating at 0.
  - U and D presses in the same cycle: no change.
  - Presses while shooting=1 are discarded, not queued.
  - sel is a register loaded every cycle with ang[turn].
- **Fire FSM:**
  - States: IDLE, FIRE, WAIT.
  - IDLE: M press with shooting=0 → FIRE and load a counter with FIRE_LEN. M=1 only in FIRE.
  - FIRE: decrements each cycle; at 1 → WAIT.
  - WAIT: holds until shooting=1 has been seen and has then returned to 0, or for 2*FIRE_LEN cycles if shooting never rises; then → IDLE.
  - M presses outside IDLE are discarded.
- **Movement:**
  - A free-running divider counts 0..MOVE_DIV-1 and pulses tick on wrap.
  - On tick with shooting=0 and FIRE_FSM=IDLE: debounced L alone decrements x[turn]; R alone increments it.
  - x is clamped to that player's [MIN, MAX].
  - L and R both held: no move.
  - The inactive player never moves.
- player_y0 and player_y1 are constant Y_GROUND.
- **Reset:** synchronisers, debouncers, divider and FSM clear.
  - Outputs after reset: M=0, sel=0, player_x0=X0_INIT, player_x1=X1_INIT, player_y*=Y_GROUND.
  - rst mid-fire drops M on the next edge.

## Timing

- Button-to-press-pulse latency: 2 sync cycles + DEBOUNCE_CYCLES.
- Angle change appears on sel 1 cycle after the press pulse.
- A turn change appears on sel 1 cycle after turn toggles.
- M rises 1 cycle after the press pulse and stays high exactly FIRE_LEN cycles.
- A position change appears 1 cycle after tick.
- A button released before its debounce completes produces no pulse.
- A press pulse coincident with shooting rising is accepted: shooting is sampled in the same cycle as the pulse, before its effect.

## Test plan

Run with DEBOUNCE_CYCLES=4, MOVE_DIV=3, FIRE_LEN=4.
- **Reset:** rst for 2 cycles → M=0, sel=0, x0=100, x1=520, y0=y1=380.
- **Debounce glitch and angle step:**
  - btnU high for 3 cycles then low → sel stays 0.
  - btnU held for 10 cycles with turn=0 → sel=1 at cycle 2+4+1.
  - Twelve further clean U presses → sel saturates at 9.
- **Per-player angle:** ang0=5. Toggle turn to 1 → sel=0 after 1 cycle; D press → sel stays 0; turn back to 0 → sel=5.
- **Fire:**
  - Clean M press with shooting=0 → M high for exactly 4 cycles.
  - Second M press during WAIT → ignored.
  - Raise then drop shooting → FSM returns to IDLE and the next press fires.
- **Move clamp and obstacle:**
  - turn=1, L held for 200 ticks → x1 stops at 340.
  - turn=0, R held for 200 ticks → x0 stops at 280.
  - L and R held together → no change.
- **Lockout:** shooting=1 while U, D, L, R pressed → sel and x unchanged; M not asserted.

Source files
------------

// File: rtl/tank_input_ctrl.sv
// Button front end for the tank game: synchronises and debounces five push-buttons and
// converts them into per-player angle selection, a stretched fire level and tank positions.
module tank_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MOVE_DIV        = 500000,
  parameter int FIRE_LEN        = 4,
  parameter int X0_INIT         = 100,
  parameter int X1_INIT         = 520,
  parameter int Y_GROUND        = 380,
  parameter int X0_MIN          = 0,
  parameter int X0_MAX          = 280,
  parameter int X1_MIN          = 340,
  parameter int X1_MAX          = 620
) (
  input  logic       clk50,
  input  logic       rst,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnM,
  input  logic       turn,
  input  logic       shooting,
  output logic       M,
  output logic [3:0] sel,
  output logic [9:0] player_x0,
  output logic [9:0] player_y0,
  output logic [9:0] player_x1,
  output logic [9:0] player_y1
);

  localparam int NB = 5;
  localparam int BL = 0, BR = 1, BU = 2, BD = 3, BM = 4;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int VW = $clog2(MOVE_DIV + 1);
  localparam int FW = $clog2(2 * FIRE_LEN + 1);

  localparam logic [9:0] X0_MIN_V = 10'(X0_MIN);
  localparam logic [9:0] X0_MAX_V = 10'(X0_MAX);
  localparam logic [9:0] X1_MIN_V = 10'(X1_MIN);
  localparam logic [9:0] X1_MAX_V = 10'(X1_MAX);

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_WAIT} fire_state_t;

  logic [NB-1:0] raw, sync1, sync2, deb, deb_q, press;
  logic [DW-1:0] db_cnt [NB];

  assign raw   = {btnM, btnD, btnU, btnR, btnL};
  assign press = deb & ~deb_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Fire FSM
  fire_state_t   state, state_nx;
  logic [FW-1:0] f_cnt, f_cnt_nx;
  logic          seen, seen_nx;

  always_ff @(posedge clk50) begin
    if (rst) begin
      state <= S_IDLE;
      f_cnt <= '0;
      seen  <= 1'b0;
    end else begin
      state <= state_nx;
      f_cnt <= f_cnt_nx;
      seen  <= seen_nx;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    f_cnt_nx = f_cnt;
    seen_nx  = seen;
    unique case (state)
      S_IDLE: begin
        seen_nx = 1'b0;
        if (press[BM] && !shooting) begin
          state_nx = S_FIRE;
          f_cnt_nx = FW'(FIRE_LEN);
        end
      end
      S_FIRE: begin
        if (f_cnt == FW'(1)) begin
          state_nx = S_WAIT;
          f_cnt_nx = FW'(2 * FIRE_LEN);
          seen_nx  = 1'b0;
        end else begin
          f_cnt_nx = f_cnt - 1'b1;
        end
      end
      S_WAIT: begin
        // Once the shot is seen, only its end releases us; otherwise a timeout does.
        if (shooting)              seen_nx  = 1'b1;
        else if (seen)             state_nx = S_IDLE;
        else if (f_cnt == FW'(1))  state_nx = S_IDLE;
        else                       f_cnt_nx = f_cnt - 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign M = (state == S_FIRE);

  // Angles
  logic [3:0] ang0, ang1, ang_cur, ang_upd;

  always_comb begin
    ang_cur = turn ? ang1 : ang0;
    ang_upd = ang_cur;
    if (!shooting && (press[BU] ^ press[BD])) begin
      if (press[BU]) begin
        if (ang_cur != 4'd9) ang_upd = ang_cur + 1'b1;
      end else begin
        if (ang_cur != 4'd0) ang_upd = ang_cur - 1'b1;
      end
    end
  end

  // sel takes the post-update angle so a press shows one cycle after its pulse.
  always_ff @(posedge clk50) begin
    if (rst) begin
      ang0 <= '0;
      ang1 <= '0;
      sel  <= '0;
    end else begin
      if (turn) ang1 <= ang_upd;
      else      ang0 <= ang_upd;
      sel <= ang_upd;
    end
  end

  // Movement
  logic [VW-1:0] div;
  logic          tick, move_ok;
  logic [9:0]    x_cur, x_min, x_max, x_upd;

  assign tick    = (div == VW'(MOVE_DIV - 1));
  assign move_ok = tick && !shooting && (state == S_IDLE);

  always_comb begin
    x_cur = turn ? player_x1 : player_x0;
    x_min = turn ? X1_MIN_V : X0_MIN_V;
    x_max = turn ? X1_MAX_V : X0_MAX_V;
    x_upd = x_cur;
    if (move_ok && deb[BL] && !deb[BR]) begin
      x_upd = (x_cur > x_min) ? x_cur - 1'b1 : x_min;
    end else if (move_ok && deb[BR] && !deb[BL]) begin
      x_upd = (x_cur < x_max) ? x_cur + 1'b1 : x_max;
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      div       <= '0;
      player_x0 <= 10'(X0_INIT);
      player_x1 <= 10'(X1_INIT);
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (turn) player_x1 <= x_upd;
      else      player_x0 <= x_upd;
    end
  end

  assign player_y0 = 10'(Y_GROUND);
  assign player_y1 = 10'(Y_GROUND);

endmodule
